// File: rtl/stim_sequencer.sv
// Drives a core under test: holds its reset, then on request pulses each selected
// stimulus channel in ascending order, optionally aligned to frame sync, and counts frames.
module stim_sequencer #(
  parameter int NCH        = 4,
  parameter int RST_CYCLES = 3,
  parameter int PULSE_W    = 16,
  parameter int GAP_W      = 8,
  parameter int SYNC_VBL   = 0,
  parameter int MAX_FRAMES = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [NCH-1:0] ch_mask,
  input  logic           vblank,
  output logic           core_reset_n,
  output logic [NCH-1:0] stim,
  output logic           busy,
  output logic           done,
  output logic [7:0]     frame_count,
  output logic           timeout
);

  localparam int TMAX = (PULSE_W > GAP_W) ?
                        ((PULSE_W > RST_CYCLES) ? PULSE_W : RST_CYCLES) :
                        ((GAP_W > RST_CYCLES) ? GAP_W : RST_CYCLES);
  localparam int TW = $clog2(TMAX + 1);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FW = $clog2(MAX_FRAMES + 1);

  localparam logic [TW-1:0] RST_LAST   = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_W - 1);
  localparam logic [FW-1:0] FRAME_MAX  = FW'(MAX_FRAMES);

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    WAIT_SYNC,
    PULSE,
    GAP,
    DONE
  } state_t;

  state_t         state;
  logic [NCH-1:0] mask;
  logic [IW-1:0]  idx;
  logic [TW-1:0]  tmr;
  logic           vblank_p0;
  logic [FW-1:0]  fcnt;
  logic           vbl_rise;

  function automatic logic [IW-1:0] low_bit(input logic [NCH-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) r = IW'(i);
    return r;
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] i);
    logic [NCH-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  assign vbl_rise    = vblank & ~vblank_p0;
  assign frame_count = 8'(fcnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RST_HOLD;
      core_reset_n <= 1'b0;
      stim         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mask         <= '0;
      idx          <= '0;
      tmr          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RST_HOLD: begin
          if (tmr == RST_LAST) begin
            state        <= IDLE;
            core_reset_n <= 1'b1;
            tmr          <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            tmr  <= '0;
            if (ch_mask == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              mask <= ch_mask;
              idx  <= low_bit(ch_mask);
              if (SYNC_VBL != 0) begin
                state <= WAIT_SYNC;
              end else begin
                state <= PULSE;
                stim  <= onehot(low_bit(ch_mask));
              end
            end
          end
        end
        WAIT_SYNC: begin
          if (vbl_rise) begin
            state <= PULSE;
            stim  <= onehot(idx);
            tmr   <= '0;
          end
        end
        PULSE: begin
          if (tmr == PULSE_LAST) begin
            // Retire this channel so the gap can pick the next higher one.
            state     <= GAP;
            stim      <= '0;
            tmr       <= '0;
            mask[idx] <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        GAP: begin
          if (tmr == GAP_LAST) begin
            tmr <= '0;
            if (mask == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx <= low_bit(mask);
              if (SYNC_VBL != 0) begin
                state <= WAIT_SYNC;
              end else begin
                state <= PULSE;
                stim  <= onehot(low_bit(mask));
              end
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= RST_HOLD;
      endcase
    end
  end

  // Frame counter runs only once the core is out of reset and saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_p0 <= 1'b1;
      fcnt      <= '0;
      timeout   <= 1'b0;
    end else begin
      vblank_p0 <= vblank;
      if (core_reset_n && vbl_rise && (fcnt != FRAME_MAX)) begin
        fcnt <= fcnt + 1'b1;
        if (fcnt == FRAME_MAX - 1'b1) timeout <= 1'b1;
      end
    end
  end

endmodule
